// File: rtl/marker_frame_sched_if.sv
// Result hand-off bus of the marker frame scheduler: snapshot payload plus valid/ready.
interface marker_frame_sched_if #(
   parameter int unsigned NUM_TARGETS = 4,
   parameter int unsigned XW          = 12,
   parameter int unsigned YW          = 11
);
   logic [NUM_TARGETS*XW-1:0] x_out;
   logic [NUM_TARGETS*YW-1:0] y_out;
   logic [NUM_TARGETS*YW-1:0] d_out;
   logic [NUM_TARGETS-1:0]    mask_out;
   logic                      out_valid;
   logic                      out_ready;

   modport master (
      output x_out, y_out, d_out, mask_out, out_valid,
      input  out_ready
   );

   modport slave (
      input  x_out, y_out, d_out, mask_out, out_valid,
      output out_ready
   );
endinterface

// File: rtl/marker_frame_sched.sv
// Frame sequencer for the marker detector: clear, capture, settle, snapshot, present.
// Optional capture watchdog enabled by defining SCHED_WDOG_EN.
module marker_frame_sched #(
   parameter int unsigned SCREEN_WIDTH  = 1280,
   parameter int unsigned SCREEN_HEIGHT = 720,
   parameter int unsigned NUM_TARGETS   = 4,
   parameter int unsigned SETTLE_CYCLES = 4,
   parameter int unsigned LOCK_FRAMES   = 3,
   parameter int unsigned LOST_FRAMES   = 8,
   parameter int unsigned WDOG_CYCLES   = 2000000,
   localparam int unsigned XW = $clog2(SCREEN_WIDTH) + 1,
   localparam int unsigned YW = $clog2(SCREEN_HEIGHT) + 1
) (
   input  logic                      clk_in,
   input  logic                      rst_in,
   input  logic [XW-1:0]             hcount_in,
   input  logic [YW-1:0]             vcount_in,
   input  logic [NUM_TARGETS*XW-1:0] x_in,
   input  logic [NUM_TARGETS*YW-1:0] y_in,
   input  logic [NUM_TARGETS*YW-1:0] d_in,
   input  logic [NUM_TARGETS-1:0]    valid_in,
   output logic                      det_rst_out,
   marker_frame_sched_if.master      res,
   output logic                      lock_out,
   output logic [7:0]                drop_cnt_out,
   output logic [1:0]                state_out,
   output logic                      wdog_out
);

   typedef enum logic [1:0] {
      StIdle    = 2'd0,
      StCapture = 2'd1,
      StSettle  = 2'd2,
      StPresent = 2'd3
   } state_e;

   state_e                    state_q;
   logic [7:0]                settle_q;
   logic [7:0]                full_q, miss_q, drop_q;
   logic                      lock_q, det_rst_q, valid_q, wdog_q;
   logic [NUM_TARGETS*XW-1:0] x_q;
   logic [NUM_TARGETS*YW-1:0] y_q, d_q;
   logic [NUM_TARGETS-1:0]    mask_q;

   logic       sof, eof, xfer, wdog_hit;
   logic [7:0] full_inc, miss_inc, drop_inc;

   assign sof  = (hcount_in == '0) && (vcount_in == '0);
   assign eof  = (hcount_in == XW'(SCREEN_WIDTH - 1)) && (vcount_in == YW'(SCREEN_HEIGHT - 1));
   assign xfer = valid_q && res.out_ready;

   always_comb begin
      full_inc = (full_q == 8'hFF) ? full_q : full_q + 8'd1;
      miss_inc = (miss_q == 8'hFF) ? miss_q : miss_q + 8'd1;
      drop_inc = (drop_q == 8'hFF) ? drop_q : drop_q + 8'd1;
   end

`ifdef SCHED_WDOG_EN
   localparam int unsigned WW = $clog2(WDOG_CYCLES + 1);
   logic [WW-1:0] wdog_cnt_q;

   // Held at zero outside CAPTURE, so every entry starts a fresh count.
   always_ff @(posedge clk_in) begin
      if (!rst_in || state_q != StCapture) begin
         wdog_cnt_q <= '0;
      end else begin
         wdog_cnt_q <= wdog_cnt_q + 1'b1;
      end
   end

   assign wdog_hit = (state_q == StCapture) && (wdog_cnt_q == WW'(WDOG_CYCLES - 1));
`else
   logic unused_wdog;
   assign unused_wdog = ^WDOG_CYCLES;
   assign wdog_hit    = 1'b0;
`endif

   always_ff @(posedge clk_in) begin
      if (!rst_in) begin
         state_q   <= StIdle;
         settle_q  <= '0;
         full_q    <= '0;
         miss_q    <= '0;
         drop_q    <= '0;
         lock_q    <= 1'b0;
         det_rst_q <= 1'b1;
         valid_q   <= 1'b0;
         wdog_q    <= 1'b0;
         x_q       <= '0;
         y_q       <= '0;
         d_q       <= '0;
         mask_q    <= '0;
      end else begin
         if (xfer) valid_q <= 1'b0;
         unique case (state_q)
            StIdle, StPresent: begin
               det_rst_q <= 1'b1;
               if (sof) begin
                  state_q   <= StCapture;
                  det_rst_q <= 1'b0;
               end
            end
            StCapture: begin
               det_rst_q <= 1'b0;
               if (eof) begin
                  state_q  <= StSettle;
                  settle_q <= 8'(SETTLE_CYCLES - 1);
               end else if (wdog_hit) begin
                  state_q   <= StIdle;
                  det_rst_q <= 1'b1;
                  wdog_q    <= 1'b1;
               end else if (sof) begin
                  // Broken frame: restart accumulation without a snapshot.
                  det_rst_q <= 1'b1;
               end
            end
            StSettle: begin
               if (settle_q == 8'd0) begin
                  x_q       <= x_in;
                  y_q       <= y_in;
                  d_q       <= d_in;
                  mask_q    <= valid_in;
                  valid_q   <= 1'b1;
                  det_rst_q <= 1'b1;
                  state_q   <= StPresent;
                  if (valid_q && !res.out_ready) drop_q <= drop_inc;
                  if (&valid_in) begin
                     full_q <= full_inc;
                     miss_q <= '0;
                     if (full_inc >= 8'(LOCK_FRAMES)) lock_q <= 1'b1;
                  end else begin
                     miss_q <= miss_inc;
                     full_q <= '0;
                     if (miss_inc >= 8'(LOST_FRAMES)) lock_q <= 1'b0;
                  end
               end else begin
                  settle_q <= settle_q - 8'd1;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign det_rst_out   = det_rst_q;
   assign res.x_out     = x_q;
   assign res.y_out     = y_q;
   assign res.d_out     = d_q;
   assign res.mask_out  = mask_q;
   assign res.out_valid = valid_q;
   assign lock_out      = lock_q;
   assign drop_cnt_out  = drop_q;
   assign state_out     = state_q;
   assign wdog_out      = wdog_q;

endmodule

// File: doc/marker_frame_sched.md
Name: marker_frame_sched

Overview:
- Frame-level sequencer for the marker-detect datapath. Each frame it clears the target detector, lets it accumulate over the active area, and waits out the detector pipeline latency after end-of-frame.
- It then snapshots the 4 target results into stable registers and hands them to the downstream consumer over valid/ready.
- It also tracks multi-frame lock status (all targets found) and counts dropped results.

Parameters:
- SCREEN_WIDTH, 1280, active pixels per line
- SCREEN_HEIGHT, 720, active lines per frame
- NUM_TARGETS, 4, number of target slots
- SETTLE_CYCLES, 4, cycles between end-of-frame and result snapshot (detector pipeline depth); legal range 1..255
- LOCK_FRAMES, 3, consecutive full-mask frames needed to assert lock
- LOST_FRAMES, 8, consecutive non-full frames needed to drop lock
- WDOG_CYCLES, 2000000, max cycles in CAPTURE before watchdog abort (used only with the optional feature)
- XW = $clog2(SCREEN_WIDTH)+1 and YW = $clog2(SCREEN_HEIGHT)+1 are localparams.

Ports:
- clk_in  in  1  system clock
- rst_in  in  1  reset, synchronous, active-low
- hcount_in  in  XW  pixel column
- vcount_in  in  YW  pixel row
- x_in  in  NUM_TARGETS*XW  detector x results; slice i = target i
- y_in  in  NUM_TARGETS*YW  detector y results
- d_in  in  NUM_TARGETS*YW  detector diameters
- valid_in  in  NUM_TARGETS  detector valid; bit i = target i
- det_rst_out  out  1  active-high clear to the detector
- x_out  out  NUM_TARGETS*XW  snapshot x
- y_out  out  NUM_TARGETS*YW  snapshot y
- d_out  out  NUM_TARGETS*YW  snapshot diameter
- mask_out  out  NUM_TARGETS  snapshot valid mask
- out_valid  out  1  snapshot available
- out_ready  in  1  consumer accepts
- lock_out  out  1  lock status
- drop_cnt_out  out  8  saturating count of overwritten, unconsumed snapshots
- state_out  out  2  FSM state: IDLE=0, CAPTURE=1, SETTLE=2, PRESENT=3
- wdog_out  out  1  watchdog abort flag

Behaviour:
- All outputs are registered.
- Reset (rst_in=0 at a clock edge): state IDLE, det_rst_out=1, out_valid=0, all snapshot/mask outputs 0, lock_out=0, drop_cnt_out=0, wdog_out=0, all internal counters 0.
- Events:
  - SOF = (hcount_in==0 && vcount_in==0).
  - EOF = (hcount_in==SCREEN_WIDTH-1 && vcount_in==SCREEN_HEIGHT-1).
- IDLE: det_rst_out=1. On SOF: next state CAPTURE, det_rst_out=0 the following cycle.
- CAPTURE: det_rst_out=0.
  - On EOF: go to SETTLE and load the settle counter with SETTLE_CYCLES-1.
  - On SOF without a prior EOF (broken frame): stay in CAPTURE, pulse det_rst_out for 1 cycle, no snapshot, lock counters untouched.
  - SOF and EOF in the same cycle (1x1 screen only): EOF wins.
- SETTLE: the counter decrements each cycle. When it reaches 0, the snapshot is taken at that edge:
  - x/y/d/mask outputs <= inputs;
  - out_valid <= 1;
  - det_rst_out <= 1;
  - next state PRESENT.
  - EOF-to-out_valid latency is exactly SETTLE_CYCLES+1 cycles.
- PRESENT: det_rst_out=1. On SOF: next state CAPTURE, det_rst_out=0.
- Handshake: transfer occurs when out_valid && out_ready. out_valid clears the next cycle. Snapshot outputs hold until the next snapshot and never change while out_valid=1, except on overwrite.
- Overwrite: a snapshot taken while out_valid is already 1 replaces the data, keeps out_valid=1, and increments drop_cnt_out (saturates at 255). A transfer in the same cycle as a snapshot is not a drop: the new data is presented and out_valid stays 1.
- Lock: evaluated at each snapshot using two saturating counters, full_cnt and miss_cnt.
  - mask all ones: full_cnt++, miss_cnt=0.
  - otherwise: miss_cnt++, full_cnt=0.
  - lock_out sets when full_cnt reaches LOCK_FRAMES and clears when miss_cnt reaches LOST_FRAMES; otherwise it holds.
  - lock_out updates on the same edge as out_valid.
- Reset mid-frame: returns to IDLE. Detection resumes only at the next SOF, so a partial frame is never snapshotted.

Optional Feature:
- Macro SCHED_WDOG_EN.
- Defined: a cycle counter runs while in CAPTURE and clears on entry.
  - Reaching WDOG_CYCLES: state goes to IDLE, det_rst_out=1, wdog_out=1.
  - wdog_out is sticky until reset.
  - out_valid and the snapshot are unaffected.
- Undefined: no counter; wdog_out is tied 0 and CAPTURE waits indefinitely.

Test Plan:
All scenarios use SCREEN_WIDTH=16, SCREEN_HEIGHT=8, SETTLE_CYCLES=4.
- Reset then idle counts -> state_out=0, det_rst_out=1, out_valid=0, lock_out=0, drop_cnt_out=0.
- Full frame with valid_in=4'b1111 and x slice0=5 held; out_ready=1 -> out_valid rises exactly 5 cycles after EOF, x_out slice0=5, mask_out=4'hF, det_rst_out=1, out_valid drops the next cycle.
- 3 full-mask frames -> lock_out=1 after the 3rd snapshot. Then 8 frames with valid_in=4'b0111 -> lock_out stays 1 through 7 and clears at the 8th.
- out_ready=0 across 3 frames -> drop_cnt_out=2, outputs show the 3rd frame's data. Then raise out_ready -> one transfer, out_valid=0.
- SOF injected mid-CAPTURE (vcount jumps to 0) -> 1-cycle det_rst_out pulse, no snapshot, the next full frame snapshots normally. rst_in=0 during SETTLE -> IDLE, no out_valid.
- With SCHED_WDOG_EN and WDOG_CYCLES=50: SOF then hcount frozen -> state_out=0 and wdog_out=1 after 50 cycles. Without the macro -> state_out stays 1 and wdog_out=0.
